// File: rtl/uart_pkg.sv
// Shared UART constants used by uart_impl users and the transmit FIFO.
//   UART_BYTE_W : width of one character on the line
//   UART_XON    : resume character for software flow control
//   UART_XOFF   : pause character for software flow control
package uart_pkg;
  localparam int UART_BYTE_W = 8;
  localparam logic [UART_BYTE_W-1:0] UART_XON  = 8'h11;
  localparam logic [UART_BYTE_W-1:0] UART_XOFF = 8'h13;
endpackage

// File: rtl/byte_fifo_mem.sv
// Byte storage for the transmit FIFO: simple dual-port array with one
// synchronous write port and an asynchronous read port, so it maps onto
// distributed RAM.
// Ports:
//   clk          write clock
//   we           write enable
//   waddr/wdata  write address / byte
//   raddr        read address
//   rdata        byte at raddr (combinational)
import uart_pkg::*;

module byte_fifo_mem #(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_BYTE_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [UART_BYTE_W-1:0] rdata
);

  logic [UART_BYTE_W-1:0] mem [DEPTH];

  // No reset: contents are only ever read behind a valid count.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter. Absorbs bursts from the
// producer and drains one byte per txready/txstrobe handshake.
// Optional XON/XOFF pause, enabled by defining UART_TX_FIFO_XONXOFF_EN.
// Ports:
//   clk, rst           clock, async active-high reset
//   wr_data, wr_en     enqueue side; writes while full are dropped
//   full, count        occupancy status (registered count)
//   overflow, ovf_clr  sticky drop flag and its clear (set wins)
//   txdata, txstrobe   byte and one-cycle send pulse to the transmitter
//   txready            transmitter idle
//   rxdata, rxstrobe   received bytes, watched for XON/XOFF
//   paused             XOFF in effect (0 when flow control is disabled)
import uart_pkg::*;

module uart_tx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   wr_en,
  output logic                   full,
  output logic [CW-1:0]          count,
  output logic                   overflow,
  input  logic                   ovf_clr,
  output logic [UART_BYTE_W-1:0] txdata,
  output logic                   txstrobe,
  input  logic                   txready,
  input  logic [UART_BYTE_W-1:0] rxdata,
  input  logic                   rxstrobe,
  output logic                   paused
);

  logic [AW-1:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]          cnt;
  logic [UART_BYTE_W-1:0] rd_byte;
  logic                   empty, accept, pop;

  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(DEPTH));
  assign count  = cnt;
  assign accept = wr_en && !full;
  // txready is still high in the cycle the strobe is out; gating on
  // txstrobe keeps that cycle from issuing a second byte.
  assign pop    = txready && !empty && !txstrobe && !paused;

  byte_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      txdata   <= '0;
      txstrobe <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        txdata <= rd_byte;
      end
      txstrobe <= pop;
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // Full is judged before the edge, so a same-cycle pop does not
      // rescue a write seen while full.
      if (wr_en && full) overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
    end
  end

`ifdef UART_TX_FIFO_XONXOFF_EN
  logic paused_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  paused_q <= 1'b0;
    else if (rxstrobe && rxdata == UART_XOFF) paused_q <= 1'b1;
    else if (rxstrobe && rxdata == UART_XON)  paused_q <= 1'b0;
  end

  assign paused = paused_q;
`else
  logic unused_rx;
  assign unused_rx = ^{rxdata, rxstrobe};
  assign paused    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus a random
// phase, all compared cycle by cycle against a queue-based model.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       ovf_clr;
  logic [7:0] txdata;
  logic       txstrobe;
  logic       txready;
  logic [7:0] rxdata;
  logic       rxstrobe;
  logic       paused;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .txdata   (txdata),
    .txstrobe (txstrobe),
    .txready  (txready),
    .rxdata   (rxdata),
    .rxstrobe (rxstrobe),
    .paused   (paused)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [7:0] mq[$];
  logic       m_strobe, m_ovf, m_paused;
  logic [7:0] m_txdata;

  int         n_tests = 0, n_fail = 0;
  bit         tx_auto = 0;
  int         busy = 0;
  bit         prev_strobe = 0;
  logic [7:0] sent[$];
  logic [7:0] wrote[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_strobe = 0; m_txdata = 0; m_ovf = 0; m_paused = 0;
    prev_strobe = 0; busy = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_strobe"},   txstrobe, m_strobe);
    check({pfx, "_txdata"},   txdata,   m_txdata);
    check({pfx, "_count"},    count,    mq.size());
    check({pfx, "_full"},     full,     mq.size() == DEPTH);
    check({pfx, "_overflow"}, overflow, m_ovf);
    check({pfx, "_paused"},   paused,   m_paused);
  endtask

  // One clock: advance the model with the inputs present at the edge,
  // then compare and run the transmitter model.
  task automatic step();
    bit was_full;
    @(posedge clk);
    was_full = (mq.size() == DEPTH);
    if (txready && mq.size() > 0 && !m_strobe && !m_paused) begin
      m_txdata = mq.pop_front();
      m_strobe = 1;
    end else m_strobe = 0;
    if (wr_en && !was_full) mq.push_back(wr_data);
    if (wr_en && was_full) m_ovf = 1;
    else if (ovf_clr)      m_ovf = 0;
`ifdef UART_TX_FIFO_XONXOFF_EN
    if (rxstrobe && rxdata == 8'h13)      m_paused = 1;
    else if (rxstrobe && rxdata == 8'h11) m_paused = 0;
`endif
    #1;
    check_outputs("cyc");
    if (txstrobe) begin
      check("strobe_gap", prev_strobe, 0);
      sent.push_back(txdata);
    end
    prev_strobe = txstrobe;
    if (tx_auto) begin
      if (txstrobe) begin
        txready = 0;
        busy = $urandom_range(1, 6);
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) txready = 1;
      end
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1; wr_data = b;
    step();
    wr_en = 0;
  endtask

  initial begin
    rst = 1; wr_data = 0; wr_en = 0; ovf_clr = 0; txready = 0;
    rxdata = 0; rxstrobe = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 0;

    // single byte with an idle transmitter
    sent.delete();
    txready = 1;
    push(8'h41);
    step();
    check("single_strobe", txstrobe, 1);
    check("single_data",   txdata,   8'h41);
    step();
    check("single_cnt0",   count,    0);
    repeat (3) step();
    check("single_once",   sent.size(), 1);

    // burst to full with a busy transmitter, then overflow
    txready = 0;
    for (int i = 0; i < 16; i++) push(8'(i));
    check("burst_full",  full,  1);
    check("burst_count", count, 16);
    push(8'hAA);
    check("burst_ovf",   overflow, 1);
    ovf_clr = 1;
    push(8'hBB);
    check("ovf_set_wins", overflow, 1);
    step();
    ovf_clr = 0;
    check("ovf_cleared",  overflow, 0);
    sent.delete();
    txready = 1;
    repeat (40) step();
    check("drain_n", sent.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < sent.size()) check("drain_order", sent[i], i);

    // three bytes, txready held high
    txready = 0;
    wrote.delete();
    for (int i = 0; i < 3; i++) begin
      wrote.push_back(8'($urandom));
      push(wrote[i]);
    end
    sent.delete();
    txready = 1;
    repeat (10) step();
    check("three_n", sent.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < sent.size()) check("three_data", sent[i], wrote[i]);

    // simultaneous accept and pop at count 5
    txready = 0;
    for (int i = 0; i < 5; i++) push(8'($urandom));
    txready = 1;
    push(8'h55);
    check("accpop_cnt", count, 5);
    repeat (15) step();
    check("accpop_drained", count, 0);

`ifdef UART_TX_FIFO_XONXOFF_EN
    begin
      bit seen;
      txready = 0;
      for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
      sent.delete();
      txready = 1; rxstrobe = 1; rxdata = 8'h13;
      step();
      rxstrobe = 0;
      repeat (6) step();
      check("xoff_paused", paused, 1);
      check("xoff_inflight_only", sent.size(), 1);
      check("xoff_count", count, 3);
      rxstrobe = 1; rxdata = 8'h11;
      step();
      rxstrobe = 0;
      seen = 0;
      for (int i = 0; i < 2; i++) begin
        step();
        if (txstrobe) seen = 1;
      end
      check("xon_resume", seen, 1);
      repeat (10) step();
    end
`endif

    // reset in the middle of a drain
    txready = 0;
    for (int i = 0; i < 6; i++) push(8'($urandom));
    txready = 1;
    repeat (3) step();
    rst = 1;
    #1;
    model_reset();
    check_outputs("midrst");
    #1;
    rst = 0;
    step();
    check("midrst_idle", txstrobe, 0);

    // random traffic with a self-timed transmitter
    tx_auto = 1; txready = 1; busy = 0;
    for (int n = 0; n < 3000; n++) begin
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_data  = 8'($urandom);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      rxstrobe = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       rxdata = 8'h13;
        1:       rxdata = 8'h11;
        default: rxdata = 8'($urandom);
      endcase
      step();
    end
    wr_en = 0; ovf_clr = 0;
    rxstrobe = 1; rxdata = 8'h11;
    step();
    rxstrobe = 0;
    repeat (200) step();
    check("final_empty", count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
